// File: rtl/cmi_mem_slave.sv
// CMI slave for a local memory array: decodes address cycles, runs a
// req/ack access on the memory port and returns one CMI response cycle.
module cmi_mem_slave #(
  parameter int                  ADDR_BITS = 22,
  parameter logic [23:ADDR_BITS] BASE_SEL  = '0,
  parameter int                  TIMEOUT   = 63
) (
  input  logic                 b_clk_l,
  input  logic                 mseq_init_l,
  input  logic                 dbbz_l,
  input  logic [31:0]          cmi_h,
  output logic [31:0]          cmi_out_h,
  output logic                 cmi_oe_h,
  output logic                 dbbz_out_l,
  output logic [1:0]           st_out_l,
  output logic                 mem_req_h,
  output logic                 mem_we_h,
  output logic [ADDR_BITS-3:0] mem_addr_h,
  output logic [3:0]           mem_be_h,
  output logic [31:0]          mem_wdata_h,
  input  logic [31:0]          mem_rdata_h,
  input  logic                 mem_ack_h,
  input  logic                 mem_err_h,
  output logic                 lock_h
);

  typedef enum logic [1:0] {
    IDLE, WDAT, ACC, RESP
  } state_t;

  localparam logic [5:0] TMO = 6'(TIMEOUT);
  localparam logic [2:0] F_RD_LOCK = 3'b001;
  localparam logic [2:0] F_WR_UNLK = 3'b101;

  state_t      state, nxt;
  logic        dbbz_del_h;
  logic [5:0]  cnt;
  logic [2:0]  func_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        fn_ok;
  logic        accept;
  logic        acc_done;
  logic        resp_oe;

  wire       addr_cyc = ~dbbz_l & dbbz_del_h;
  wire [2:0] fn       = cmi_h[27:25];
  wire       unused_bits = ^{cmi_h[24], cmi_h[1:0]};

  always_comb begin
    fn_ok = 1'b0;
    unique case (fn)
      3'b000, 3'b001, 3'b010,
      3'b100, 3'b101: fn_ok = 1'b1;
      default:        fn_ok = 1'b0;
    endcase
  end

  assign accept   = addr_cyc & fn_ok &
                    (cmi_h[23:ADDR_BITS] == BASE_SEL);
  assign acc_done = mem_ack_h | (cnt == TMO);

  always_ff @(posedge b_clk_l or negedge mseq_init_l) begin
    if (!mseq_init_l) state <= IDLE;
    else              state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (accept) nxt = fn[2] ? WDAT : ACC;
      WDAT: nxt = ACC;
      ACC:  if (acc_done) nxt = RESP;
      RESP: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Outputs decode registered state only, never live inputs.
  always_comb begin
    resp_oe    = (state == RESP) & ~mem_we_h;
    dbbz_out_l = ~((state == WDAT) | (state == ACC));
    mem_req_h  = (state == ACC);
    st_out_l   = (state == RESP) ? {err_q, 1'b0} : 2'b11;
    cmi_oe_h   = resp_oe;
    cmi_out_h  = resp_oe ? rdata_q : 32'h0;
  end

  always_ff @(posedge b_clk_l or negedge mseq_init_l) begin
    if (!mseq_init_l) begin
      dbbz_del_h  <= 1'b1;
      cnt         <= '0;
      func_q      <= '0;
      mem_we_h    <= 1'b0;
      mem_be_h    <= '0;
      mem_addr_h  <= '0;
      mem_wdata_h <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      lock_h      <= 1'b0;
    end else begin
      dbbz_del_h <= dbbz_l;
      cnt        <= (state == ACC) ? cnt + 6'd1 : 6'd0;
      if (state == IDLE && accept) begin
        func_q     <= fn;
        mem_we_h   <= fn[2];
        mem_be_h   <= fn[2] ? cmi_h[31:28] : 4'hf;
        mem_addr_h <= cmi_h[ADDR_BITS-1:2];
      end
      if (state == WDAT) mem_wdata_h <= cmi_h;
      if (state == ACC) begin
        if (mem_ack_h) begin
          rdata_q <= mem_rdata_h;
          err_q   <= mem_err_h;
        end else if (cnt == TMO) begin
          err_q <= 1'b1;
        end
      end
      // Lock changes land together with the response cycle.
      if (state == ACC && acc_done) begin
        if (func_q == F_RD_LOCK && mem_ack_h && !mem_err_h)
          lock_h <= 1'b1;
        if (func_q == F_WR_UNLK)
          lock_h <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cmi_mem_slave.sv
// Scoreboard bench for cmi_mem_slave: random CMI traffic against a
// transaction-level model plus a behavioural memory device.
module tb_cmi_mem_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mbusy_l = 1'b1;
  logic [31:0] cmi_h = '0;
  logic [31:0] cmi_out_h;
  logic        cmi_oe_h;
  logic        dbbz_out_l;
  logic [1:0]  st_out_l;
  logic        mem_req_h;
  logic        mem_we_h;
  logic [19:0] mem_addr_h;
  logic [3:0]  mem_be_h;
  logic [31:0] mem_wdata_h;
  logic [31:0] mem_rdata_h = '0;
  logic        mem_ack_h = 1'b0;
  logic        mem_err_h = 1'b0;
  logic        lock_h;

  wire dbbz_l = mbusy_l & dbbz_out_l;

  cmi_mem_slave dut (
    .b_clk_l(clk), .mseq_init_l(rst_n), .dbbz_l(dbbz_l),
    .cmi_h(cmi_h), .cmi_out_h(cmi_out_h), .cmi_oe_h(cmi_oe_h),
    .dbbz_out_l(dbbz_out_l), .st_out_l(st_out_l),
    .mem_req_h(mem_req_h), .mem_we_h(mem_we_h),
    .mem_addr_h(mem_addr_h), .mem_be_h(mem_be_h),
    .mem_wdata_h(mem_wdata_h), .mem_rdata_h(mem_rdata_h),
    .mem_ack_h(mem_ack_h), .mem_err_h(mem_err_h), .lock_h(lock_h)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]  st;
    bit          rd;
    bit          chk_data;
    logic [31:0] data;
    bit          lock;
    int          cyc;
    int          busy;
  } resp_t;

  typedef struct {
    bit          we;
    logic [19:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          waits;
    bit          err;
  } req_t;

  resp_t resp_q[$];
  req_t  req_q[$];
  logic [31:0] model_mem[int];
  logic [31:0] dev_mem[int];
  bit    lock_m = 0;
  int    busy_run = 0;
  int    n_chk = 0;
  int    n_fail = 0;

  function automatic logic [31:0] init_val(int a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  function automatic logic [31:0] model_get(int a);
    return model_mem.exists(a) ? model_mem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] dev_get(int a);
    return dev_mem.exists(a) ? dev_mem[a] : init_val(a);
  endfunction

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic flag(string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Response monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (st_out_l != 2'b11) begin
        if (resp_q.size() == 0) begin
          flag("unexpected_resp");
        end else begin
          resp_t r;
          r = resp_q.pop_front();
          check("resp_status", st_out_l, r.st);
          check("resp_oe", cmi_oe_h, r.rd);
          if (r.rd && r.chk_data) check("resp_data", cmi_out_h, r.data);
          check("resp_cycle", cyc, r.cyc);
          check("busy_cycles", busy_run, r.busy);
          check("resp_lock", lock_h, r.lock);
        end
        busy_run = 0;
      end else begin
        check("idle_bus", {cmi_oe_h, cmi_out_h}, 33'h0);
        if (dbbz_out_l) busy_run = 0;
        else            busy_run++;
      end
    end
  end

  // Memory device
  bit   dev_active = 0;
  int   wcnt = 0;
  req_t cur;
  always @(negedge clk) begin
    if (!rst_n || !mem_req_h) begin
      dev_active = 0;
      mem_ack_h  = 0;
      mem_err_h  = 0;
    end else begin
      if (!dev_active) begin
        dev_active = 1;
        if (req_q.size() == 0) begin
          flag("unexpected_req");
          cur = '{we: 0, addr: 0, be: 0, wdata: 0, waits: -1, err: 0};
        end else begin
          cur = req_q.pop_front();
          check("req_we", mem_we_h, cur.we);
          check("req_addr", mem_addr_h, cur.addr);
          check("req_be", mem_be_h, cur.be);
          if (cur.we) check("req_wdata", mem_wdata_h, cur.wdata);
        end
        wcnt = cur.waits;
      end
      if (wcnt == 0) begin
        mem_ack_h   = 1;
        mem_err_h   = cur.err;
        mem_rdata_h = dev_get(int'(mem_addr_h));
        if (mem_we_h) begin
          logic [31:0] v;
          v = dev_get(int'(mem_addr_h));
          for (int b = 0; b < 4; b++)
            if (mem_be_h[b]) v[b*8 +: 8] = mem_wdata_h[b*8 +: 8];
          dev_mem[int'(mem_addr_h)] = v;
        end
      end else begin
        mem_ack_h = 0;
        if (wcnt > 0) wcnt--;
      end
    end
  end

  // Drive one address cycle (plus data cycle); record expectations.
  task automatic issue(input logic [2:0] f, input logic [3:0] m,
                       input logic [23:0] a, input logic [31:0] wd,
                       input int waits, input bit err, output bit acc);
    bit wr;
    int A;
    wr  = f[2];
    acc = (f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) && a[23:22] == 2'b00;
    @(posedge clk); #1;
    mbusy_l = 0;
    cmi_h   = {m, f, 1'b0, a};
    A       = cyc;
    if (acc) begin
      req_t  q;
      resp_t r;
      bit    tmo;
      int    dur;
      int    idx;
      idx = int'(a[21:2]);
      tmo = waits < 0;
      q = '{we: wr, addr: a[21:2], be: wr ? m : 4'hf,
            wdata: wd, waits: waits, err: err};
      req_q.push_back(q);
      dur = (wr ? 1 : 0) + (tmo ? 64 : waits + 1);
      r.st       = (tmo || err) ? 2'b10 : 2'b00;
      r.rd       = !wr;
      r.chk_data = !tmo;
      r.data     = model_get(idx);
      r.cyc      = A + 1 + dur;
      r.busy     = dur;
      if (f == 3'd1 && r.st == 2'b00) lock_m = 1;
      if (f == 3'd5) lock_m = 0;
      r.lock = lock_m;
      if (wr && !tmo) begin
        logic [31:0] v;
        v = model_get(idx);
        for (int b = 0; b < 4; b++)
          if (m[b]) v[b*8 +: 8] = wd[b*8 +: 8];
        model_mem[idx] = v;
      end
      resp_q.push_back(r);
    end
    @(posedge clk); #1;
    mbusy_l = 1;
    cmi_h   = wr ? wd : $urandom;
  endtask

  task automatic txn(input logic [2:0] f, input logic [3:0] m,
                     input logic [23:0] a, input logic [31:0] wd,
                     input int waits, input bit err);
    bit acc;
    issue(f, m, a, wd, waits, err, acc);
    if (acc) begin
      for (int i = 0; i < 200 && resp_q.size() != 0; i++)
        @(posedge clk);
      if (resp_q.size() != 0) begin
        flag("resp_wait_expired");
        resp_q.delete();
        req_q.delete();
      end
    end else begin
      bit seen;
      seen = 0;
      repeat (6) begin
        @(negedge clk);
        if (!dbbz_out_l || mem_req_h || st_out_l != 2'b11) seen = 1;
      end
      check("ignored_quiet", seen, 1'b0);
    end
    @(posedge clk); #1;
    cmi_h = $urandom;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    model_mem[32'h41] = 32'hDEADBEEF;
    dev_mem[32'h41]   = 32'hDEADBEEF;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dbbz", dbbz_out_l, 1'b1);
    check("rst_st", st_out_l, 2'b11);
    check("rst_out", {cmi_oe_h, cmi_out_h}, 33'h0);
    check("rst_mem", {mem_req_h, mem_we_h, mem_be_h, mem_addr_h,
                      mem_wdata_h}, 58'h0);
    check("rst_lock", lock_h, 1'b0);
    @(negedge clk);
    rst_n = 1;

    txn(3'd0, 4'hf, 24'h000104, 32'h0, 0, 0);
    txn(3'd4, 4'h3, 24'h000200, 32'h12345678, 3, 0);
    txn(3'd0, 4'hf, 24'h000200, 32'h0, 1, 0);
    txn(3'd1, 4'hf, 24'h000010, 32'h0, 0, 0);
    txn(3'd5, 4'hf, 24'h000010, 32'hCAFEF00D, 2, 0);
    txn(3'd1, 4'hf, 24'h000014, 32'h0, 0, 1);
    txn(3'd0, 4'hf, 24'h400104, 32'h0, 0, 0);
    txn(3'd6, 4'hf, 24'h000100, 32'h55AA55AA, 0, 0);
    txn(3'd0, 4'hf, 24'h000020, 32'h0, -1, 0);
    txn(3'd2, 4'hf, 24'h000024, 32'h0, 4, 0);

    for (int n = 0; n < 60; n++) begin
      logic [2:0]  f;
      logic [23:0] a;
      int          r;
      int          w;
      f = 3'($urandom_range(0, 7));
      a = {($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
           14'h0, 6'($urandom_range(0, 15)), 2'($urandom)};
      r = $urandom_range(0, 24);
      w = (r == 0) ? -1 : r % 5;
      txn(f, 4'($urandom), a, $urandom, w, $urandom_range(0, 7) == 0);
    end

    txn(3'd1, 4'hf, 24'h000030, 32'h0, 0, 0);
    issue(3'd0, 4'hf, 24'h000034, 32'h0, -1, 0, acc);
    repeat (8) @(posedge clk);
    #3;
    rst_n = 0;
    #1;
    check("async_rst_req", mem_req_h, 1'b0);
    check("async_rst_dbbz", dbbz_out_l, 1'b1);
    check("async_rst_st", st_out_l, 2'b11);
    check("async_rst_lock", lock_h, 1'b0);
    resp_q.delete();
    req_q.delete();
    lock_m   = 0;
    busy_run = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    txn(3'd0, 4'hf, 24'h000104, 32'h0, 1, 0);
    txn(3'd4, 4'h9, 24'h000034, 32'hA5A5C3C3, 0, 0);
    txn(3'd0, 4'hf, 24'h000034, 32'h0, 0, 0);

    repeat (4) @(posedge clk);
    check("req_q_drained", req_q.size(), 0);
    check("resp_q_drained", resp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cmi_mem_slave.md
# cmi_mem_slave

CMI slave port for a local memory array: the block that consumes the CPU-side CMI transactions launched by the CMI control chip. It detects CMI address cycles and decodes function, byte mask and address. It captures write data, runs a request/acknowledge access on the local memory port, holds `dbbz_out_l` for the duration, then ends the transaction with one response cycle carrying CMI status and, for reads, data. It also tracks the CMI interlock set by read-lock and cleared by write-unlock.

## Interface
- `ADDR_BITS`, default 22: byte-address span decoded by this slave (2^22 B).
- `BASE_SEL`, default 2'b00: required value of CMI address bits [23:ADDR_BITS].
- `TIMEOUT`, default 63: maximum ACC cycles before the access is aborted (6-bit counter).
- `b_clk_l`  in  1  bus clock; all flops update on its rising edge.
- `mseq_init_l`  in  1  reset, asynchronous, active-low.
- `dbbz_l`  in  1  CMI bus busy (wired-OR, active-low).
- `cmi_h`  in  32  CMI lines.
  - Address cycle: [31:28] byte mask, [27:25] function, [23:0] address.
  - Data cycle: write data.
- `cmi_out_h`  out  32  read data; 0 when `cmi_oe_h`=0.
- `cmi_oe_h`  out  1  drive enable for `cmi_out_h`.
- `dbbz_out_l`  out  1  slave holds bus busy.
- `st_out_l`  out  2  CMI status, active-low; 2'b11 when idle.
- `mem_req_h`  out  1  memory access request.
- `mem_we_h`  out  1  1 = write.
- `mem_addr_h`  out  ADDR_BITS-2  longword address (`cmi_h[ADDR_BITS-1:2]`).
- `mem_be_h`  out  4  byte enables.
- `mem_wdata_h`  out  32  write data.
- `mem_rdata_h`  in  32  read data, valid with `mem_ack_h`.
- `mem_ack_h`  in  1  access complete.
- `mem_err_h`  in  1  uncorrectable error, valid with `mem_ack_h`.
- `lock_h`  out  1  interlock held.

## Operation
- Registered `dbbz_del_h` holds the previous `dbbz_l`. An address cycle is `~dbbz_l & dbbz_del_h` (falling edge of busy), sampled in IDLE only.
- Accepted functions:
  - Reads: 000 RD, 001 RD_LOCK, 010 RD_LMOD.
  - Writes: 100 WR, 101 WR_UNLK.
- Ignored: 110 WR_VEC, 011, 111, and any address with [23:ADDR_BITS] ≠ `BASE_SEL`. On an ignored cycle, state stays IDLE, no outputs change, and the master times out (NXM).
- States:
  - IDLE: on an accepted address cycle, latch function, mask and address. Go to WDAT if the function is a write, else ACC.
  - WDAT: `dbbz_out_l`=0. Latch `cmi_h` into `mem_wdata_h`, then go to ACC.
  - ACC: `dbbz_out_l`=0, `mem_req_h`=1. Clear the 6-bit counter on entry and increment it each cycle.
    - `mem_ack_h` sampled 1: latch `mem_rdata_h` and `mem_err_h`, go to RESP.
    - Counter = `TIMEOUT` without ack: go to RESP with error.
  - RESP, one cycle:
    - `dbbz_out_l`=1.
    - `st_out_l`=2'b00 (OK) or 2'b10 (UCE, on error or timeout).
    - Reads: `cmi_oe_h`=1 and `cmi_out_h`=latched data.
    - Next state is IDLE.
- `mem_be_h`: latched mask for writes, 4'b1111 for reads.
- `mem_we_h`: 1 for writes, valid while `mem_req_h`=1.
- Lock:
  - RD_LOCK with OK status sets `lock_h` in RESP.
  - WR_UNLK clears `lock_h` in RESP regardless of status.
  - The lock does not block other accesses.
- `mem_ack_h` and `mem_err_h` outside ACC are ignored.
- An address cycle while not IDLE is ignored; busy held low continuously never re-triggers.

## Timing
- Reset values:
  - State IDLE.
  - `dbbz_out_l`=1, `st_out_l`=2'b11, `cmi_oe_h`=0, `cmi_out_h`=0.
  - `mem_req_h`=0, `mem_we_h`=0, `mem_be_h`=0, `mem_addr_h`=0, `mem_wdata_h`=0.
  - `lock_h`=0, `dbbz_del_h`=1, counter 0.
- Reset mid-transaction: everything returns to the reset values immediately and asynchronously. No response is issued and the pending access is abandoned.
- Cycle A is the address cycle. Read with ack in its first ACC cycle: ACC at A+1, RESP at A+2. Write: WDAT at A+1, ACC at A+2, RESP at A+3.
- Every ack-wait cycle adds one cycle. Timeout: ACC lasts `TIMEOUT`+1 cycles, then RESP.
- `dbbz_out_l` is low continuously from A+1 through the last ACC cycle, so the master's busy never sees a gap.
- All outputs are registered; none depend combinationally on inputs.

## Test plan
- RD at 0x000104, mask 1111, ack in first ACC cycle with rdata 0xDEADBEEF: RESP at A+2 with `st_out_l`=00, `cmi_out_h`=0xDEADBEEF, `cmi_oe_h`=1; `dbbz_out_l` low A+1..A+1 only.
- WR at 0x000200, mask 0011, data 0x12345678, ack after 3 wait cycles: `mem_be_h`=0011, `mem_wdata_h`=0x12345678, `mem_addr_h`=0x80, RESP at A+6 with `st_out_l`=00.
- RD_LOCK then WR_UNLK: `lock_h` rises in the first RESP and falls in the second; RD_LOCK acked with `mem_err_h`=1 gives `st_out_l`=10 and `lock_h` stays 0.
- Address bits [23:22]=01 with `BASE_SEL`=00, and function 110 at a matching address: no `dbbz_out_l`, no `mem_req_h`, `st_out_l` stays 11.
- Read with `mem_ack_h` never asserted: `mem_req_h` high 64 cycles, then RESP with `st_out_l`=10 and `mem_req_h` dropping.
- Assert `mseq_init_l`=0 during ACC: `mem_req_h`=0 and `dbbz_out_l`=1 without waiting for a clock edge; the next address cycle after reset is served normally.
